mem_request_unit: RTL and testbench
===================================

// Module: mem_request_unit
// PURPOSE
// - Sits between the datapath's memory interface and the single shared memory bus.
// - Serialises instruction fetches and data load/store requests onto one Wishbone-style classic bus.
// - Returns fetched words and load data to the datapath, each with a one-cycle acknowledge pulse.
// - Data accesses take priority over fetches: the pending load/store belongs to the instruction in flight.
// PARAMETERS
// - TIMEOUT_CYCLES  255  bus cycles to wait for bus_ack before aborting (used only with MEM_TIMEOUT_EN).
// - TO_W            8    width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES.
// PORTS
// - clk          in   1   system clock; all logic on rising edge.
// - rst          in   1   synchronous, active-high reset.
// - i_req        in   1   datapath requests an instruction fetch at i_address.
// - i_address    in   32  fetch address.
// - d_read       in   1   datapath requests a load from d_address.
// - d_write      in   1   datapath requests a store of mem_store to d_address.
// - d_address    in   32  data address.
// - mem_store    in   32  store data.
// - d_sel        in   4   store byte enables.
// - instruction  out  32  last fetched word, held until the next fetch completes.
// - memload      out  32  last load word, held until the next load completes.
// - i_ack        out  1   one-cycle pulse: fetch complete, instruction valid.
// - d_ack        out  1   one-cycle pulse: load/store complete.
// - bus_cyc      out  1   bus cycle active.
// - bus_stb      out  1   bus strobe (equal to bus_cyc).
// - bus_we       out  1   1 = write.
// - bus_adr      out  32  word-aligned address: {addr[31:2],2'b00}.
// - bus_dat_o    out  32  write data.
// - bus_sel      out  4   byte enables; 4'hF on reads.
// - bus_dat_i    in   32  read data; valid when bus_ack=1.
// - bus_ack      in   1   slave completes the current cycle.
// - bus_err      out  1   sticky timeout flag; cleared only by rst.
// BEHAVIOUR
// - FSM states: IDLE, DATA, FETCH, ACK. All outputs are registered.
// - Reset values: state IDLE; instruction, memload, bus_adr, bus_dat_o = 0; all 1-bit outputs = 0; bus_sel = 0.
// - IDLE -> DATA when (d_read | d_write). IDLE -> FETCH when i_req and no data request.
//   - On that transition edge: latch address, data, sel and we; assert bus_cyc/bus_stb.
// - d_read and d_write both high is treated as a write.
// - DATA/FETCH: cyc/stb/adr/we/dat_o/sel held constant until bus_ack=1.
//   - On the ack edge: drop cyc/stb, capture bus_dat_i into memload (load) or instruction (fetch), pulse d_ack or i_ack, go to ACK.
// - Stores leave memload unchanged.
// - ACK: ack pulse is high for exactly this cycle; requests are ignored; next state IDLE.
//   - Gives the datapath one cycle to retire or change its request.
// - Minimum latency: request seen at edge N, bus_cyc high from N; with a zero-wait slave (ack at N+1), ack pulse at N+2.
// - Back-to-back requests: one transaction per 3 cycles minimum.
// - bus_ack seen in IDLE or ACK is ignored.
// - Requests dropped while in DATA/FETCH: the bus transaction still completes and the ack is still pulsed.
// - rst mid-transaction: bus_cyc/stb low on the next edge, state IDLE, no ack pulse; a late bus_ack is ignored.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined:
//   - A counter runs in DATA/FETCH and is cleared on entry to either state.
//   - If it reaches TIMEOUT_CYCLES without bus_ack: drop cyc/stb, set bus_err, go to ACK, pulse the pending ack.
//   - On a fetch timeout, instruction = 32'h0000_0013 (NOP); on a load timeout, memload = 32'h0.
// - MEM_TIMEOUT_EN undefined: the unit waits indefinitely for bus_ack; bus_err is tied 0 and no counter is built.
// TESTING
// - Reset: assert rst 2 cycles with bus_ack=1 -> all outputs 0, bus_cyc stays 0.
// - Fetch: i_req=1, i_address=32'h0000_0104, slave acks 1 cycle after cyc with 32'h00A08193 -> bus_adr=32'h104, bus_we=0, bus_sel=4'hF, instruction=32'h00A08193, i_ack high exactly 1 cycle, 2 cycles after request.
// - Priority: i_req=1 and d_write=1 in the same cycle, d_address=32'h0000_2003, mem_store=32'd30, d_sel=4'h1 -> first cycle bus_we=1, bus_adr=32'h2000, bus_dat_o=30; d_ack pulses; then a fetch cycle; then i_ack pulses.
// - Wait states: d_read with slave acking 5 cycles late, data 32'd30 -> cyc/adr stable all 5 cycles, memload=30, single d_ack pulse, instruction unchanged.
// - Reset mid-cycle: rst during FETCH, then slave acks -> cyc drops, no i_ack, instruction unchanged (0).
// - MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, slave never acks a fetch -> cyc drops after 4 cycles, bus_err=1 (sticky), instruction=32'h00000013, i_ack pulses once.

Source files
------------

// File: rtl/mem_request_unit.sv
// mem_request_unit: serialises instruction fetches and data loads/stores onto one classic Wishbone bus.
// Define MEM_TIMEOUT_EN to abort bus cycles that see no bus_ack within TIMEOUT_CYCLES (sticky bus_err).
module mem_request_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] mem_store,
    input  logic [3:0]  d_sel,
    output logic [31:0] instruction,
    output logic [31:0] memload,
    output logic        i_ack,
    output logic        d_ack,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack,
    output logic        bus_err
);

    // state | meaning
    // IDLE  | no bus cycle; a data request wins over a fetch
    // DATA  | load/store bus cycle in progress
    // FETCH | instruction fetch bus cycle in progress
    // ACK   | ack pulse to the datapath; requests ignored
    typedef enum logic [1:0] {IDLE, DATA, FETCH, ACK} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if (2**TO_W <= TIMEOUT_CYCLES) begin : g_to_w_check
        $error("TO_W is too narrow to count TIMEOUT_CYCLES");
    end

    state_t state, state_next;
    logic   start_data, start_fetch, bus_done, timed_out, busy;

    assign busy = (state == DATA) || (state == FETCH);

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Down-counter loaded on entry; terminal count with no ack aborts the cycle.
    assign timed_out = busy && !bus_ack && (to_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            if (start_data || start_fetch)
                to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
            else if (busy && (to_cnt != '0))
                to_cnt <= to_cnt - TO_W'(1);
            if (timed_out)
                bus_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        start_data  = 1'b0;
        start_fetch = 1'b0;
        bus_done    = 1'b0;
        case (state)
            IDLE: begin
                if (d_read || d_write) begin
                    start_data = 1'b1;
                    state_next = DATA;
                end else if (i_req) begin
                    start_fetch = 1'b1;
                    state_next  = FETCH;
                end
            end
            DATA, FETCH: begin
                if (bus_ack || timed_out) begin
                    bus_done   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= '0;
            memload     <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            bus_cyc     <= 1'b0;
            bus_stb     <= 1'b0;
            bus_we      <= 1'b0;
            bus_adr     <= '0;
            bus_dat_o   <= '0;
            bus_sel     <= '0;
        end else begin
            state <= state_next;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (start_data) begin
                bus_cyc   <= 1'b1;
                bus_stb   <= 1'b1;
                bus_we    <= d_write;
                bus_adr   <= {d_address[31:2], 2'b00};
                bus_dat_o <= mem_store;
                bus_sel   <= d_write ? d_sel : 4'hF;
            end else if (start_fetch) begin
                bus_cyc <= 1'b1;
                bus_stb <= 1'b1;
                bus_we  <= 1'b0;
                bus_adr <= {i_address[31:2], 2'b00};
                bus_sel <= 4'hF;
            end else if (bus_done) begin
                bus_cyc <= 1'b0;
                bus_stb <= 1'b0;
                if (state == DATA) begin
                    d_ack <= 1'b1;
                    if (!bus_we)
                        memload <= bus_ack ? bus_dat_i : 32'h0;
                end else begin
                    i_ack       <= 1'b1;
                    instruction <= bus_ack ? bus_dat_i : NOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: expectations are queued as requests are driven
// and compared when the DUT pulses i_ack/d_ack. Build with MEM_TIMEOUT_EN to add the timeout scenario.
module tb_mem_request_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_CYC    = 4;
    localparam int WAIT_LATE = 2;
`else
    localparam int TO_CYC    = 255;
    localparam int WAIT_LATE = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_read, d_write;
    logic [31:0] i_address, d_address, mem_store;
    logic [3:0]  d_sel;
    logic [31:0] instruction, memload;
    logic        i_ack, d_ack;
    logic        bus_cyc, bus_stb, bus_we;
    logic [31:0] bus_adr, bus_dat_o, bus_dat_i;
    logic [3:0]  bus_sel;
    logic        bus_ack, bus_err;

    int checks = 0;
    int passed = 0;

    mem_request_unit #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_address(i_address),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .mem_store(mem_store), .d_sel(d_sel),
        .instruction(instruction), .memload(memload),
        .i_ack(i_ack), .d_ack(d_ack),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_adr(bus_adr), .bus_dat_o(bus_dat_o), .bus_sel(bus_sel),
        .bus_dat_i(bus_dat_i), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat_o;
        logic [31:0] data;
        logic [31:0] other;
        logic [3:0]  sel;
    } exp_t;

    typedef struct packed {
        logic        got;
        logic        is_fetch;
        logic        both;
        logic        we;
        logic        unstable;
        logic        width_ok;
        logic [31:0] adr;
        logic [31:0] dat_o;
        logic [31:0] data;
        logic [31:0] other;
        logic [3:0]  sel;
        int          latency;
        int          cyc_cycles;
    } obs_t;

    exp_t        sb[$];
    logic [31:0] smem[logic [31:0]];
    logic [31:0] tmem[logic [31:0]];
    logic [31:0] cur_instr = 32'h0;
    logic [31:0] cur_mload = 32'h0;

    logic force_ack   = 1'b0;
    int   slave_wait  = 0;

    // Slave: acks slave_wait cycles after it first sees cyc; force_ack drives a stray ack.
    initial begin
        int wcnt;
        wcnt      = 0;
        bus_ack   = 1'b0;
        bus_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                bus_ack   = 1'b1;
                bus_dat_i = 32'hBAD0_BAD0;
            end else if (bus_cyc && !bus_ack) begin
                if (wcnt >= slave_wait) begin
                    bus_ack   = 1'b1;
                    bus_dat_i = smem.exists(bus_adr) ? smem[bus_adr] : ~bus_adr;
                    if (bus_we) smem[bus_adr] = bus_dat_o;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                bus_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Waits for the next ack pulse, recording the bus cycle seen on the way; retires the request.
    task automatic collect(input int budget, output obs_t o);
        bit seen;
        o    = '0;
        seen = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (bus_cyc) begin
                o.cyc_cycles = o.cyc_cycles + 1;
                if (!seen) begin
                    seen    = 1'b1;
                    o.adr   = bus_adr;
                    o.we    = bus_we;
                    o.sel   = bus_sel;
                    o.dat_o = bus_dat_o;
                    if (!bus_stb) o.unstable = 1'b1;
                end else if ({bus_adr, bus_we, bus_sel, bus_dat_o, bus_stb} !==
                             {o.adr, o.we, o.sel, o.dat_o, 1'b1}) begin
                    o.unstable = 1'b1;
                end
            end
            if (i_ack || d_ack) begin
                o.got      = 1'b1;
                o.is_fetch = i_ack;
                o.both     = i_ack && d_ack;
                o.latency  = n;
                o.data     = i_ack ? instruction : memload;
                o.other    = i_ack ? memload : instruction;
                if (i_ack) i_req = 1'b0;
                else begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
                @(negedge clk);
                o.width_ok = !i_ack && !d_ack;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit bad;
        rst       = 1'b1;
        force_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus_cyc, bus_stb, bus_we, i_ack, d_ack, bus_err} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {bus_cyc, bus_stb, bus_we, i_ack, d_ack, bus_err}); else passed++;
        checks++; if (bus_adr !== 32'h0) $display("FAIL reset_adr: got %h want 0", bus_adr); else passed++;
        checks++; if (bus_dat_o !== 32'h0) $display("FAIL reset_dat_o: got %h want 0", bus_dat_o); else passed++;
        checks++; if (bus_sel !== 4'h0) $display("FAIL reset_sel: got %h want 0", bus_sel); else passed++;
        checks++; if ({instruction, memload} !== 64'h0)
            $display("FAIL reset_data: got %h/%h want 0/0", instruction, memload); else passed++;
        rst = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_cyc || i_ack || d_ack) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) $display("FAIL idle_ack_ignored: got activity=%b want 0", bad); else passed++;
        force_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        exp_t e;
        obs_t o;
        smem[32'h104] = 32'h00A0_8193;
        sb.push_back('{is_fetch: 1'b1, we: 1'b0, adr: 32'h104, dat_o: 32'h0,
                       data: 32'h00A0_8193, other: cur_mload, sel: 4'hF});
        slave_wait = 0;
        i_address  = 32'h0000_0104;
        i_req      = 1'b1;
        collect(20, o);
        e = sb.pop_front();
        cur_instr = e.data;
        checks++; if (o.got !== 1'b1) $display("FAIL fetch_ack_seen: got %b want 1", o.got); else passed++;
        checks++; if (o.is_fetch !== e.is_fetch) $display("FAIL fetch_kind: got i_ack=%b want %b", o.is_fetch, e.is_fetch); else passed++;
        checks++; if (o.adr !== e.adr) $display("FAIL fetch_adr: got %h want %h", o.adr, e.adr); else passed++;
        checks++; if ({o.we, o.sel} !== {e.we, e.sel}) $display("FAIL fetch_we_sel: got %b/%h want %b/%h", o.we, o.sel, e.we, e.sel); else passed++;
        checks++; if (o.data !== e.data) $display("FAIL fetch_instruction: got %h want %h", o.data, e.data); else passed++;
        checks++; if (o.latency !== 2) $display("FAIL fetch_latency: got %0d want 2", o.latency); else passed++;
        checks++; if (o.width_ok !== 1'b1) $display("FAIL fetch_ack_width: ack still high on second cycle"); else passed++;
        checks++; if (o.other !== e.other) $display("FAIL fetch_memload_kept: got %h want %h", o.other, e.other); else passed++;
    endtask

    task automatic test_priority;
        exp_t e;
        obs_t o;
        smem[32'h108] = 32'h0000_0513;
        sb.push_back('{is_fetch: 1'b0, we: 1'b1, adr: 32'h2000, dat_o: 32'd30,
                       data: cur_mload, other: cur_instr, sel: 4'h1});
        sb.push_back('{is_fetch: 1'b1, we: 1'b0, adr: 32'h108, dat_o: 32'h0,
                       data: 32'h0000_0513, other: cur_mload, sel: 4'hF});
        slave_wait = 1;
        i_address  = 32'h0000_0108;
        d_address  = 32'h0000_2003;
        mem_store  = 32'd30;
        d_sel      = 4'h1;
        i_req      = 1'b1;
        d_write    = 1'b1;
        for (int t = 0; t < 2; t++) begin
            collect(20, o);
            e = sb.pop_front();
            checks++; if ({o.got, o.is_fetch} !== {1'b1, e.is_fetch})
                $display("FAIL prio_order[%0d]: got ack=%b fetch=%b want 1/%b", t, o.got, o.is_fetch, e.is_fetch); else passed++;
            checks++; if ({o.adr, o.we, o.sel} !== {e.adr, e.we, e.sel})
                $display("FAIL prio_bus[%0d]: got %h/%b/%h want %h/%b/%h", t, o.adr, o.we, o.sel, e.adr, e.we, e.sel); else passed++;
            checks++; if (o.data !== e.data) $display("FAIL prio_data[%0d]: got %h want %h", t, o.data, e.data); else passed++;
            checks++; if (o.other !== e.other) $display("FAIL prio_other[%0d]: got %h want %h", t, o.other, e.other); else passed++;
            checks++; if (o.width_ok !== 1'b1) $display("FAIL prio_ack_width[%0d]: ack longer than one cycle", t); else passed++;
            if (!e.is_fetch) begin
                checks++; if (o.dat_o !== e.dat_o) $display("FAIL prio_dat_o: got %0d want %0d", o.dat_o, e.dat_o); else passed++;
            end
        end
        cur_instr = 32'h0000_0513;
        tmem[32'h2000] = 32'd30;
    endtask

    task automatic test_wait_states;
        exp_t e;
        obs_t o;
        sb.push_back('{is_fetch: 1'b0, we: 1'b0, adr: 32'h2000, dat_o: 32'h0,
                       data: 32'd30, other: cur_instr, sel: 4'hF});
        slave_wait = WAIT_LATE;
        d_address  = 32'h0000_2000;
        d_read     = 1'b1;
        collect(40, o);
        e = sb.pop_front();
        cur_mload = e.data;
        checks++; if ({o.got, o.is_fetch} !== 2'b10) $display("FAIL wait_kind: got ack=%b fetch=%b want 1/0", o.got, o.is_fetch); else passed++;
        checks++; if (o.cyc_cycles !== WAIT_LATE + 1) $display("FAIL wait_cyc_len: got %0d want %0d", o.cyc_cycles, WAIT_LATE + 1); else passed++;
        checks++; if (o.unstable !== 1'b0) $display("FAIL wait_bus_stable: bus changed while cyc high"); else passed++;
        checks++; if ({o.adr, o.we, o.sel} !== {e.adr, e.we, e.sel})
            $display("FAIL wait_bus: got %h/%b/%h want %h/%b/%h", o.adr, o.we, o.sel, e.adr, e.we, e.sel); else passed++;
        checks++; if (o.data !== e.data) $display("FAIL wait_memload: got %0d want %0d", o.data, e.data); else passed++;
        checks++; if (o.width_ok !== 1'b1) $display("FAIL wait_ack_width: more than one d_ack cycle"); else passed++;
        checks++; if (o.other !== e.other) $display("FAIL wait_instr_kept: got %h want %h", o.other, e.other); else passed++;
        checks++; if (o.latency !== WAIT_LATE + 2) $display("FAIL wait_latency: got %0d want %0d", o.latency, WAIT_LATE + 2); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs[3];
        addrs      = '{32'h3000, 32'h3004, 32'h3008};
        slave_wait = 0;
        for (int i = 0; i < 10; i++) begin
            exp_t        e;
            obs_t        o;
            int          k;
            logic [31:0] a, wd;
            logic [3:0]  s;
            a  = addrs[(i < 3) ? i : int'($urandom_range(0, 2))];
            k  = (i < 3) ? 1 : int'($urandom_range(0, 2));
            wd = $urandom;
            s  = 4'($urandom_range(1, 15));
            if (k == 1) begin
                e = '{is_fetch: 1'b0, we: 1'b1, adr: a, dat_o: wd, data: cur_mload, other: cur_instr, sel: s};
                tmem[a]   = wd;
                d_address = a | 32'($urandom_range(0, 3));
                mem_store = wd;
                d_sel     = s;
                d_write   = 1'b1;
                d_read    = i[0];
            end else if (k == 0) begin
                e = '{is_fetch: 1'b0, we: 1'b0, adr: a, dat_o: 32'h0, data: tmem[a], other: cur_instr, sel: 4'hF};
                cur_mload = tmem[a];
                d_address = a | 32'($urandom_range(0, 3));
                d_read    = 1'b1;
            end else begin
                e = '{is_fetch: 1'b1, we: 1'b0, adr: a, dat_o: 32'h0, data: tmem[a], other: cur_mload, sel: 4'hF};
                cur_instr = tmem[a];
                i_address = a;
                i_req     = 1'b1;
            end
            sb.push_back(e);
            collect(20, o);
            e = sb.pop_front();
            checks++; if ({o.got, o.both, o.is_fetch} !== {1'b1, 1'b0, e.is_fetch})
                $display("FAIL b2b_kind[%0d]: got ack=%b both=%b fetch=%b want 1/0/%b", i, o.got, o.both, o.is_fetch, e.is_fetch); else passed++;
            checks++; if ({o.adr, o.we, o.sel} !== {e.adr, e.we, e.sel})
                $display("FAIL b2b_bus[%0d]: got %h/%b/%h want %h/%b/%h", i, o.adr, o.we, o.sel, e.adr, e.we, e.sel); else passed++;
            checks++; if ({o.data, o.other} !== {e.data, e.other})
                $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", i, o.data, o.other, e.data, e.other); else passed++;
            checks++; if ({o.latency, o.width_ok} !== {32'sd2, 1'b1})
                $display("FAIL b2b_timing[%0d]: got latency %0d width_ok %b want 2/1", i, o.latency, o.width_ok); else passed++;
            if (e.we) begin
                checks++; if (o.dat_o !== e.dat_o) $display("FAIL b2b_dat_o[%0d]: got %h want %h", i, o.dat_o, e.dat_o); else passed++;
            end
        end
        checks++; if (bus_err !== 1'b0) $display("FAIL b2b_no_err: got bus_err=%b want 0", bus_err); else passed++;
    endtask

    task automatic test_drop_request;
        exp_t e;
        obs_t o;
        bit   bad;
        sb.push_back('{is_fetch: 1'b0, we: 1'b0, adr: 32'h3004, dat_o: 32'h0,
                       data: tmem[32'h3004], other: cur_instr, sel: 4'hF});
        slave_wait = 2;
        d_address  = 32'h0000_3004;
        d_read     = 1'b1;
        @(negedge clk);
        d_read = 1'b0;
        collect(20, o);
        e = sb.pop_front();
        cur_mload = e.data;
        checks++; if ({o.got, o.is_fetch} !== 2'b10) $display("FAIL drop_ack: got ack=%b fetch=%b want 1/0", o.got, o.is_fetch); else passed++;
        checks++; if (o.data !== e.data) $display("FAIL drop_memload: got %h want %h", o.data, e.data); else passed++;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_cyc || i_ack || d_ack) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) $display("FAIL drop_no_retry: got activity=%b want 0", bad); else passed++;
    endtask

    task automatic test_reset_mid;
        bit bad;
        slave_wait = 3;
        i_address  = 32'h0000_0200;
        i_req      = 1'b1;
        @(negedge clk);
        checks++; if (bus_cyc !== 1'b1) $display("FAIL rstmid_started: got cyc=%b want 1", bus_cyc); else passed++;
        rst   = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        checks++; if ({bus_cyc, bus_stb, i_ack} !== 3'b000) $display("FAIL rstmid_abort: got cyc/stb/i_ack=%b want 000", {bus_cyc, bus_stb, i_ack}); else passed++;
        checks++; if (instruction !== 32'h0) $display("FAIL rstmid_instr: got %h want 0", instruction); else passed++;
        rst       = 1'b0;
        force_ack = 1'b1;
        bad       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_cyc || i_ack || d_ack) bad = 1'b1;
        end
        force_ack = 1'b0;
        checks++; if (bad !== 1'b0) $display("FAIL rstmid_late_ack: got activity=%b want 0", bad); else passed++;
        cur_instr = 32'h0;
        cur_mload = 32'h0;
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        exp_t e;
        obs_t o;
        sb.push_back('{is_fetch: 1'b1, we: 1'b0, adr: 32'h400, dat_o: 32'h0,
                       data: 32'h0000_0013, other: cur_mload, sel: 4'hF});
        slave_wait = 1000;
        i_address  = 32'h0000_0400;
        i_req      = 1'b1;
        collect(30, o);
        e = sb.pop_front();
        checks++; if ({o.got, o.is_fetch} !== 2'b11) $display("FAIL to_ack: got ack=%b fetch=%b want 1/1", o.got, o.is_fetch); else passed++;
        checks++; if (o.cyc_cycles !== TO_CYC) $display("FAIL to_cyc_len: got %0d want %0d", o.cyc_cycles, TO_CYC); else passed++;
        checks++; if (o.data !== e.data) $display("FAIL to_nop: got %h want %h", o.data, e.data); else passed++;
        checks++; if (o.width_ok !== 1'b1) $display("FAIL to_ack_width: i_ack longer than one cycle"); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (bus_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", bus_err); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        i_address = 32'h0;
        d_address = 32'h0;
        mem_store = 32'h0;
        d_sel     = 4'h0;
        test_reset;
        test_fetch;
        test_priority;
        test_wait_states;
        test_back_to_back;
        test_drop_request;
        test_reset_mid;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
